// File: rtl/piano_led_pkg.sv
// Shared types and helpers for the piano-key LED column scheduler.
package piano_led_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  localparam int LEVEL_W = 4;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 4'd15;

  // Top four bits of the slot divider select the PWM phase (16 phases per slot).
  function automatic logic [3:0] phase_slice(input logic [31:0] cnt, input int div_w);
    return 4'(cnt >> (div_w - 4));
  endfunction

endpackage

// File: rtl/led_prescaler.sv
// Slot divider: free-running DIV_W-bit counter gated by enable, with a
// synchronous clear; emits the end-of-slot tick and the current PWM phase.
module led_prescaler
  import piano_led_pkg::*;
#(
  parameter int DIV_W = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       clr_i,
  output logic       tick_o,
  output logic [3:0] phase_o
);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clr_i) begin
      div_cnt_d = '0;
    end else if (en_i) begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  assign tick_o  = (&div_cnt_q) & en_i;
  assign phase_o = phase_slice(32'(div_cnt_q), DIV_W);

endmodule

// File: rtl/piano_led_sched.sv
// Time-multiplexed PWM scheduler for the piano-key LED column with per-key decaying brightness.
// Optional PIANO_LED_BLANK_EN blanks led_out during the first 1/16 of each slot (anti-ghosting).
module piano_led_sched
  import piano_led_pkg::*;
#(
  parameter int NUM_KEYS    = 8,
  parameter int DIV_W       = 11,
  parameter int DECAY_TICKS = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                led_en,
  input  logic [NUM_KEYS-1:0] key_hit,
  output logic [NUM_KEYS-1:0] led_sel,
  output logic                led_out,
  output logic                busy
);

  localparam int COL_W = $clog2(NUM_KEYS);
  localparam int DEC_W = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_KEYS - 1);
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECAY_TICKS - 1);

  state_e                             state_q, state_d;
  logic [COL_W-1:0]                   col_idx_q, col_idx_d;
  logic [DEC_W-1:0]                   decay_cnt_q, decay_cnt_d;
  logic [NUM_KEYS-1:0][LEVEL_W-1:0]   level_q, level_d, level_dec;
  logic [NUM_KEYS-1:0]                led_sel_q, led_sel_d;
  logic                               led_out_q, led_out_d;
  logic                               scan_en, pre_clr, tick, decay_wrap;
  logic                               all_zero, any_hit, blank;
  logic [3:0]                         phase;

  assign scan_en    = (state_q == SCAN) & led_en;
  assign any_hit    = |key_hit;
  assign decay_wrap = tick & (decay_cnt_q == DEC_LAST);

  led_prescaler #(
    .DIV_W(DIV_W)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (scan_en),
    .clr_i  (pre_clr),
    .tick_o (tick),
    .phase_o(phase)
  );

  // A strike overrides a same-cycle decay of that key.
  always_comb begin
    level_dec = level_q;
    level_d   = level_q;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (decay_wrap && (level_q[i] != '0)) begin
        level_dec[i] = level_q[i] - LEVEL_W'(1);
      end
      level_d[i] = key_hit[i] ? LEVEL_MAX : level_dec[i];
    end
    all_zero = (level_dec == '0);
  end

  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    decay_cnt_d = decay_cnt_q;
    pre_clr     = 1'b0;
    case (state_q)
      IDLE: begin
        pre_clr     = 1'b1;
        col_idx_d   = '0;
        decay_cnt_d = '0;
        if (any_hit) begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (tick) begin
          col_idx_d   = (col_idx_q == COL_LAST) ? '0 : col_idx_q + COL_W'(1);
          decay_cnt_d = (decay_cnt_q == DEC_LAST) ? '0 : decay_cnt_q + DEC_W'(1);
          if (all_zero && !any_hit) begin
            state_d     = IDLE;
            col_idx_d   = '0;
            decay_cnt_d = '0;
            pre_clr     = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef PIANO_LED_BLANK_EN
  assign blank = (phase == 4'd0);
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    led_sel_d = '0;
    led_out_d = 1'b0;
    if (scan_en) begin
      led_sel_d = NUM_KEYS'(1) << col_idx_q;
      led_out_d = (level_q[col_idx_q] > phase) & ~blank;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_idx_q   <= '0;
      decay_cnt_q <= '0;
      level_q     <= '0;
      led_sel_q   <= '0;
      led_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      decay_cnt_q <= decay_cnt_d;
      level_q     <= level_d;
      led_sel_q   <= led_sel_d;
      led_out_q   <= led_out_d;
    end
  end

  assign led_sel = led_sel_q;
  assign led_out = led_out_q;
  assign busy    = (state_q == SCAN);

endmodule

// File: tb/tb_piano_led_sched.sv
// Directed bench for piano_led_sched (NUM_KEYS=4, DIV_W=6, DECAY_TICKS=2).
module tb_piano_led_sched;

  logic       clk;
  logic       rst_n;
  logic       led_en;
  logic [3:0] key_hit;
  logic [3:0] led_sel;
  logic       led_out;
  logic       busy;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

`ifdef PIANO_LED_BLANK_EN
  localparam int BLANK = 4;
`else
  localparam int BLANK = 0;
`endif

  piano_led_sched #(
    .NUM_KEYS   (4),
    .DIV_W      (6),
    .DECAY_TICKS(2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .led_en (led_en),
    .key_hit(key_hit),
    .led_sel(led_sel),
    .led_out(led_out),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 4 clocks per PWM phase; on for phases 0..lvl-1, minus the blanked phase 0.
  function automatic int exp_on(input int lvl);
    return (lvl == 0) ? 0 : 4 * lvl - BLANK;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Waits for key k's slot on led_sel, counts led_out-high clocks over it,
  // optionally pulsing hit_mask on sample index hit_idx.
  task automatic measure(input int k, input int hit_idx, input logic [3:0] hit_mask,
                         output int ones, output int len);
    logic [3:0] sel;
    int w;
    sel  = 4'(1 << k);
    ones = 0;
    len  = 0;
    w    = 0;
    while (led_sel !== sel && w < 1000) begin
      @(negedge clk);
      w++;
    end
    while (led_sel === sel && len < 200) begin
      if (led_out === 1'b1) ones++;
      key_hit = (len == hit_idx) ? hit_mask : 4'b0;
      len++;
      @(negedge clk);
    end
    key_hit = 4'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int ones, len, t0, w, bad, busybad;
    rst_n   = 1'b0;
    led_en  = 1'b1;
    key_hit = 4'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_sel", int'(led_sel), 0);
    chk("reset_out", int'(led_out), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Strike key 2; re-strike at the start of its slot so it shows full level.
    key_hit = 4'b0100;
    @(negedge clk);
    key_hit = 4'b0;
    chk("s1_busy", int'(busy), 1);
    measure(0, -1, 4'b0, ones, len);
    chk("s1_key0_on", ones, 0);
    measure(1, -1, 4'b0, ones, len);
    chk("s1_key1_on", ones, 0);
    measure(2, 0, 4'b0100, ones, len);
    chk("s1_key2_on", ones, exp_on(15));
    chk("s1_key2_len", len, 64);

    // Single hit on key 0: level drops every 2 slots, scan ends on tick 30.
    do_reset();
    key_hit = 4'b0001;
    @(negedge clk);
    key_hit = 4'b0;
    t0 = cyc;
    for (int j = 0; j < 8; j++) begin
      measure(0, -1, 4'b0, ones, len);
      chk($sformatf("s2_slot%0d_on", 4 * j), ones, exp_on(15 - 2 * j));
    end
    w = 0;
    while (busy === 1'b1 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk("s2_busy_clks", cyc - t0, 1920);
    repeat (2) @(negedge clk);
    chk("s2_idle_sel", int'(led_sel), 0);
    chk("s2_idle_out", int'(led_out), 0);

    // Re-strike key 1 on the very tick that decrements it.
    do_reset();
    key_hit = 4'b0010;
    @(negedge clk);
    key_hit = 4'b0;
    measure(1, 62, 4'b0010, ones, len);
    chk("s3_slot1_on", ones, exp_on(15));
    measure(1, -1, 4'b0, ones, len);
    chk("s3_slot5_on", ones, exp_on(14));

    // Pause mid-slot for 100 clocks, striking key 3 while paused.
    do_reset();
    key_hit = 4'b0001;
    @(negedge clk);
    key_hit = 4'b0;
    w = 0;
    while (led_sel !== 4'b0001 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    ones = 0;
    len  = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      len++;
      if (led_out === 1'b1) ones++;
    end
    led_en  = 1'b0;
    bad     = 0;
    busybad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (led_sel !== 4'b0 || led_out !== 1'b0) bad++;
      if (busy !== 1'b1) busybad++;
      key_hit = (i == 50) ? 4'b1000 : 4'b0;
    end
    key_hit = 4'b0;
    led_en  = 1'b1;
    @(negedge clk);
    while (led_sel === 4'b0001 && len < 200) begin
      if (led_out === 1'b1) ones++;
      len++;
      @(negedge clk);
    end
    chk("s4_pause_outputs_nonzero", bad, 0);
    chk("s4_pause_busy_low", busybad, 0);
    chk("s4_slot0_len", len, 64);
    chk("s4_slot0_on", ones, exp_on(15));
    measure(3, -1, 4'b0, ones, len);
    chk("s4_key3_on", ones, exp_on(14));

    // Asynchronous reset while key 0 is being driven.
    w = 0;
    while (!(led_sel === 4'b0001 && led_out === 1'b1) && w < 1000) begin
      @(negedge clk);
      w++;
    end
    chk("s5_pre_sel", int'(led_sel), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_async_sel", int'(led_sel), 0);
    chk("s5_async_out", int'(led_out), 0);
    chk("s5_async_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy !== 1'b0) bad++;
    end
    chk("s5_idle_busy", bad, 0);
    key_hit = 4'b0010;
    @(negedge clk);
    key_hit = 4'b0;
    measure(0, -1, 4'b0, ones, len);
    chk("s5_key0_lost", ones, 0);
    measure(3, -1, 4'b0, ones, len);
    chk("s5_key3_lost", ones, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/piano_led_sched.md
Name: piano_led_sched

Overview:
- Scheduler for the piano-key LED column: one time-multiplexed LED drive line shared across NUM_KEYS key LEDs.
- Each key hit sets that key's brightness to full; brightness then decays in steps.
- The block scans one key per slot and PWM-modulates the shared drive line from that key's brightness.
- Sits between the key-event logic and the LED pins; its internal divider replaces the standalone LED clock divider.

Parameters:
- NUM_KEYS, 8, number of key LEDs scanned; range 2..16.
- DIV_W, 11, prescaler width; one scan slot lasts 2^DIV_W clocks; must be at least 5.
- DECAY_TICKS, 64, number of slot ticks per brightness decrement; at least 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- led_en  in  1  global LED enable; low pauses the scan.
- key_hit  in  NUM_KEYS  one-cycle pulse per key strike.
- led_sel  out  NUM_KEYS  one-hot column select for the currently scanned key.
- led_out  out  1  PWM drive for the selected LED.
- busy  out  1  high while in SCAN.

Behaviour:
- Reset (async, rst_n low): state IDLE; all counters and levels 0; led_sel=0, led_out=0, busy=0.
- level[i] is 4 bits. A key_hit[i] pulse sets level[i]=15 in every state.
  - key_hit takes priority over a decrement of the same key in the same cycle.
  - key_hit is captured even while led_en is low.
- States:
  - IDLE: div_cnt, col_idx and decay_cnt held at 0; led_sel=0, led_out=0. Any key_hit -> SCAN on the next edge.
  - SCAN:
    - When led_en=1: div_cnt (DIV_W bits) increments every clk.
    - tick = (div_cnt == all-ones) & led_en.
    - On tick: col_idx advances and wraps NUM_KEYS-1 -> 0; decay_cnt advances and wraps at DECAY_TICKS-1.
    - On decay_cnt wrap: every nonzero level decrements by 1, saturating at 0.
    - When led_en=0: all counters freeze and led_sel and led_out are forced 0 (registered); levels are held.
  - SCAN -> IDLE: on a tick where all levels are 0 after that tick's decay update and no key_hit occurs in that cycle. All counters clear on entry to IDLE.
- phase = div_cnt[DIV_W-1 -: 4].
- led_sel and led_out are registered, one clk of latency after div_cnt/col_idx/level:
  - led_sel = onehot(col_idx).
  - led_out = (level[col_idx] > phase).
  - Level 15 gives a 15/16 duty cycle; level 0 is never on.
- busy = (state == SCAN), registered with the state.
- Width rules:
  - col_idx is $clog2(NUM_KEYS) bits.
  - decay_cnt is $clog2(DECAY_TICKS) bits, minimum 1 bit.
  - No arithmetic overflow beyond the explicit wraps above.
- If rst_n asserts mid-scan, all outputs drop immediately and levels are lost.

Optional Feature:
- Macro: PIANO_LED_BLANK_EN.
- Defined: led_out is forced 0 while div_cnt[DIV_W-1:DIV_W-4]==0, i.e. the first 1/16 of each slot. This is a ghosting blank between columns; peak duty becomes 14/16 for level 15. led_sel is unaffected.
- Undefined: no blanking; duty follows the rules above.

Decomposition:
- Shared package piano_led_pkg holds:
  - the state enum (IDLE, SCAN);
  - LEVEL_W=4 and LEVEL_MAX=15;
  - the phase-slice helper.
- One natural sub-module, led_prescaler: holds div_cnt, has the enable/clear inputs, and outputs tick and phase.
- Level storage, scan and the FSM stay in the top module.

Test Plan:
All scenarios use NUM_KEYS=4, DIV_W=6, DECAY_TICKS=2.
1. Reset, then pulse key_hit=4'b0100 -> busy=1 one cycle later, level[2]=15. While col_idx=2, led_sel=4'b0100 and led_out is high for 60 of the 64 clocks in that slot.
2. Single hit on key 0, no further hits -> level decrements every 2 ticks (128 clks). After 30 ticks it reaches 0 and busy falls on that tick; led_sel=0 afterwards.
3. key_hit[1] in the same cycle as a decay decrement of key 1 -> level[1]=15, not 14.
4. led_en low for 100 clks mid-slot -> led_sel=0 and led_out=0 from the next clk; div_cnt and col_idx unchanged on re-enable; a key_hit[3] during the pause gives level[3]=15.
5. Assert rst_n low mid-scan -> led_sel, led_out and busy are 0 asynchronously; after release the state is IDLE and all levels are 0.
6. With PIANO_LED_BLANK_EN defined, repeat scenario 1 -> led_out is low for the first 4 clocks of every slot and high for 56 clocks in key 2's slot.
